// File: rtl/pe_add_arb_if.sv
// Requester/pe_add bundle for pe_add_arb: operand requests, pe_add issue and result paths.
// Pure wiring; carries no state and adds no latency.
// Backpressure travels on pe_d1_bp/pe_d2_bp toward the arbiter.
interface pe_add_arb_if #(
  parameter int NREQ    = 4,
  parameter int LANES   = 8,
  parameter int W       = 64,
  parameter int MAX_OUT = 8
);
  localparam int DW = LANES * W;
  localparam int OW = $clog2(MAX_OUT) + 1;

  logic [NREQ-1:0]    req_valid;
  logic [NREQ*DW-1:0] req_d1;
  logic [NREQ*DW-1:0] req_d2;
  logic [NREQ-1:0]    req_ack;
  logic [DW-1:0]      pe_d1;
  logic [DW-1:0]      pe_d2;
  logic               pe_d1_valid;
  logic               pe_d2_valid;
  logic               pe_d1_bp;
  logic               pe_d2_bp;
  logic [DW-1:0]      pe_q;
  logic               pe_q_valid;
  logic [DW-1:0]      rsp_q;
  logic [NREQ-1:0]    rsp_valid;
  logic [OW-1:0]      outstanding;
  logic               err;

  // Arbiter side.
  modport slave (
    input  req_valid, req_d1, req_d2, pe_d1_bp, pe_d2_bp, pe_q, pe_q_valid,
    output req_ack, pe_d1, pe_d2, pe_d1_valid, pe_d2_valid, rsp_q, rsp_valid,
           outstanding, err
  );

  // Requesters plus pe_add side.
  modport master (
    output req_valid, req_d1, req_d2, pe_d1_bp, pe_d2_bp, pe_q, pe_q_valid,
    input  req_ack, pe_d1, pe_d2, pe_d1_valid, pe_d2_valid, rsp_q, rsp_valid,
           outstanding, err
  );
endinterface

// File: rtl/pe_add_arb.sv
// Round-robin arbiter sharing one pe_add among NREQ requesters, with an in-order tag FIFO for result routing.
// Latency: ACK is combinational; issue to pe_add 1 cycle after ACK; response 1 cycle after pe_q_valid.
// Backpressure: pe_add BP or a full tag FIFO (without a same-cycle pop) withholds ACK; requests wait.
module pe_add_arb #(
  parameter int NREQ    = 4,
  parameter int LANES   = 8,
  parameter int W       = 64,
  parameter int MAX_OUT = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  pe_add_arb_if.slave bus
);
  localparam int              DW       = LANES * W;
  localparam int              PW       = $clog2(NREQ);
  localparam int              AW       = $clog2(MAX_OUT);
  localparam logic [PW:0]     NREQ_X   = (PW+1)'(NREQ);
  localparam logic [PW-1:0]   LAST     = PW'(NREQ - 1);
  localparam logic [AW:0]     FULL_CNT = (AW+1)'(MAX_OUT);

  logic [PW-1:0]   r_ptr;
  logic [PW-1:0]   r_tag [MAX_OUT];
  logic [AW-1:0]   r_wp;
  logic [AW-1:0]   r_rp;
  logic [AW:0]     r_cnt;
  logic [DW-1:0]   r_pe_d1;
  logic [DW-1:0]   r_pe_d2;
  logic            r_pe_vld;
  logic [DW-1:0]   r_rsp_q;
  logic [NREQ-1:0] r_rsp_vld;
  logic            r_err;

  logic            w_pop;
  logic            w_err_hit;
  logic            w_issue_ok;
  logic            w_gnt_vld;
  logic [PW-1:0]   w_gnt_idx;
  logic [PW:0]     w_cand;
  logic [NREQ-1:0] w_ack;

  // A result with no tag to pair it with is an orphan: it pops nothing and only flags ERR.
  assign w_pop      = bus.pe_q_valid && (r_cnt != '0);
  assign w_err_hit  = bus.pe_q_valid && (r_cnt == '0);
  // Reset suppresses grants so no requester sees an ACK for work that is about to be discarded.
  assign w_issue_ok = !i_rst && !bus.pe_d1_bp && !bus.pe_d2_bp && ((r_cnt < FULL_CNT) || w_pop);

  // Round-robin pick: scan from the pointer upward with wrap; the lowest offset wins.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    w_cand    = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_cand = {1'b0, r_ptr} + (PW+1)'(k);
      if (w_cand >= NREQ_X) w_cand = w_cand - NREQ_X;
      if (bus.req_valid[w_cand[PW-1:0]]) begin
        w_gnt_vld = w_issue_ok;
        w_gnt_idx = w_cand[PW-1:0];
      end
    end
  end

  // One-hot acknowledge for the granted requester.
  always_comb begin
    w_ack = '0;
    if (w_gnt_vld) w_ack[w_gnt_idx] = 1'b1;
  end

  // Pointer, issue register, tag FIFO pointers/occupancy, response register and sticky error.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr     <= '0;
      r_wp      <= '0;
      r_rp      <= '0;
      r_cnt     <= '0;
      r_pe_d1   <= '0;
      r_pe_d2   <= '0;
      r_pe_vld  <= 1'b0;
      r_rsp_q   <= '0;
      r_rsp_vld <= '0;
      r_err     <= 1'b0;
    end else begin
      if (w_gnt_vld) r_ptr <= (w_gnt_idx == LAST) ? '0 : w_gnt_idx + 1'b1;

      r_pe_vld <= w_gnt_vld;
      r_pe_d1  <= w_gnt_vld ? bus.req_d1[int'(w_gnt_idx)*DW +: DW] : '0;
      r_pe_d2  <= w_gnt_vld ? bus.req_d2[int'(w_gnt_idx)*DW +: DW] : '0;

      if (w_gnt_vld) r_wp <= r_wp + 1'b1;
      if (w_pop)     r_rp <= r_rp + 1'b1;
      case ({w_gnt_vld, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase

      r_rsp_vld <= '0;
      if (w_pop) r_rsp_vld[r_tag[r_rp]] <= 1'b1;
      r_rsp_q   <= w_pop ? bus.pe_q : '0;

      if (w_err_hit) r_err <= 1'b1;
    end
  end

  // Tag storage needs no reset: entries are only read between push and pop.
  always_ff @(posedge i_clk) begin
    if (w_gnt_vld) r_tag[r_wp] <= w_gnt_idx;
  end

  assign bus.req_ack     = w_ack;
  assign bus.pe_d1       = r_pe_d1;
  assign bus.pe_d2       = r_pe_d2;
  assign bus.pe_d1_valid = r_pe_vld;
  assign bus.pe_d2_valid = r_pe_vld;
  assign bus.rsp_q       = r_rsp_q;
  assign bus.rsp_valid   = r_rsp_vld;
  assign bus.outstanding = r_cnt;
  assign bus.err         = r_err;
endmodule

// File: tb/tb_pe_add_arb.sv
// Bench for pe_add_arb: table-driven grant vectors, directed corner sequences, randomized run vs a queue model.
// The bench plays both the requesters and pe_add (lane-wise add with random return timing).
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_pe_add_arb;
  localparam int NREQ    = 4;
  localparam int LANES   = 8;
  localparam int W       = 64;
  localparam int MAX_OUT = 8;
  localparam int DW      = LANES * W;

  typedef logic [DW-1:0] vec_t;

  typedef struct {
    logic [NREQ-1:0] req;
    logic            bp1;
    logic            bp2;
    logic            qv;
    logic [NREQ-1:0] ack;
    int              occ;
  } row_t;

  typedef struct {
    int   id;
    vec_t sum;
  } tag_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pe_add_arb_if #(.NREQ(NREQ), .LANES(LANES), .W(W), .MAX_OUT(MAX_OUT)) bus ();

  pe_add_arb #(.NREQ(NREQ), .LANES(LANES), .W(W), .MAX_OUT(MAX_OUT)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input vec_t act, input vec_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t ramp(input int base, input int stride);
    vec_t v;
    for (int l = 0; l < LANES; l++) v[l*W +: W] = 64'(base + stride * l);
    return v;
  endfunction

  function automatic vec_t lsum(input vec_t a, input vec_t b);
    vec_t v;
    for (int l = 0; l < LANES; l++) v[l*W +: W] = a[l*W +: W] + b[l*W +: W];
    return v;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    for (int l = 0; l < LANES; l++) v[l*W +: W] = {$urandom, $urandom};
    return v;
  endfunction

  task automatic idle_inputs();
    bus.req_valid  = '0;
    bus.req_d1     = '0;
    bus.req_d2     = '0;
    bus.pe_d1_bp   = 1'b0;
    bus.pe_d2_bp   = 1'b0;
    bus.pe_q       = '0;
    bus.pe_q_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  row_t tbl [17];

  tag_t            mtags [$];
  vec_t            pe_pipe [$];
  vec_t            rd1 [NREQ];
  vec_t            rd2 [NREQ];
  logic [NREQ-1:0] rv;
  int              mptr;
  int              g;
  int              acks;
  logic            exp_pe_vld;
  vec_t            exp_d1;
  vec_t            exp_d2;
  logic [NREQ-1:0] exp_rsp;
  logic [NREQ-1:0] exp_ack;
  vec_t            exp_rsp_q;
  logic            bp1;
  logic            bp2;
  logic            qv;
  tag_t            t;

  initial begin
    // Consecutive cycles from reset: pointer and occupancy carry across rows.
    tbl[0]  = '{4'b1111, 1'b0, 1'b0, 1'b0, 4'b0001, 1};
    tbl[1]  = '{4'b1111, 1'b0, 1'b0, 1'b0, 4'b0010, 2};
    tbl[2]  = '{4'b1111, 1'b0, 1'b0, 1'b0, 4'b0100, 3};
    tbl[3]  = '{4'b1111, 1'b0, 1'b0, 1'b0, 4'b1000, 4};
    tbl[4]  = '{4'b1111, 1'b0, 1'b0, 1'b0, 4'b0001, 5};
    tbl[5]  = '{4'b0001, 1'b1, 1'b0, 1'b0, 4'b0000, 5};
    tbl[6]  = '{4'b0001, 1'b0, 1'b1, 1'b0, 4'b0000, 5};
    tbl[7]  = '{4'b0001, 1'b0, 1'b0, 1'b0, 4'b0001, 6};
    tbl[8]  = '{4'b1001, 1'b0, 1'b0, 1'b0, 4'b1000, 7};
    tbl[9]  = '{4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 7};
    tbl[10] = '{4'b0110, 1'b0, 1'b0, 1'b1, 4'b0010, 7};
    tbl[11] = '{4'b0110, 1'b0, 1'b0, 1'b0, 4'b0100, 8};
    tbl[12] = '{4'b1111, 1'b0, 1'b0, 1'b0, 4'b0000, 8};
    tbl[13] = '{4'b1111, 1'b0, 1'b0, 1'b1, 4'b1000, 8};
    tbl[14] = '{4'b0000, 1'b0, 1'b0, 1'b1, 4'b0000, 7};
    tbl[15] = '{4'b0101, 1'b1, 1'b0, 1'b1, 4'b0000, 6};
    tbl[16] = '{4'b0110, 1'b0, 1'b0, 1'b0, 4'b0010, 7};

    idle_inputs();

    // Reset state
    do_reset();
    #1;
    check("rst ack",         vec_t'(bus.req_ack),     '0);
    check("rst pe_d1_valid", vec_t'(bus.pe_d1_valid), '0);
    check("rst pe_d2_valid", vec_t'(bus.pe_d2_valid), '0);
    check("rst pe_d1",       bus.pe_d1,               '0);
    check("rst rsp_valid",   vec_t'(bus.rsp_valid),   '0);
    check("rst outstanding", vec_t'(bus.outstanding), '0);
    check("rst err",         vec_t'(bus.err),         '0);

    // Table-driven grant/occupancy sequence
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      bus.req_valid  = tbl[i].req;
      bus.pe_d1_bp   = tbl[i].bp1;
      bus.pe_d2_bp   = tbl[i].bp2;
      bus.pe_q_valid = tbl[i].qv;
      #1;
      check($sformatf("tbl%0d ack", i), vec_t'(bus.req_ack), vec_t'(tbl[i].ack));
      @(posedge clk);
      #1;
      check($sformatf("tbl%0d occ", i), vec_t'(bus.outstanding), vec_t'(tbl[i].occ));
    end

    // Single request from req0 through issue and response
    do_reset();
    @(negedge clk);
    bus.req_valid          = 4'b0001;
    bus.req_d1[DW-1:0]     = ramp(1, 1);
    bus.req_d2[DW-1:0]     = ramp(1, 1);
    #1;
    check("t1 ack", vec_t'(bus.req_ack), vec_t'(4'b0001));
    @(negedge clk);
    bus.req_valid = '0;
    #1;
    check("t1 pe_d1_valid", vec_t'(bus.pe_d1_valid), vec_t'(1'b1));
    check("t1 pe_d2_valid", vec_t'(bus.pe_d2_valid), vec_t'(1'b1));
    check("t1 pe_d1",       bus.pe_d1, ramp(1, 1));
    check("t1 pe_d2",       bus.pe_d2, ramp(1, 1));
    check("t1 outstanding", vec_t'(bus.outstanding), vec_t'(1));
    bus.pe_q       = lsum(bus.pe_d1, bus.pe_d2);
    bus.pe_q_valid = 1'b1;
    @(negedge clk);
    bus.pe_q_valid = 1'b0;
    bus.pe_q       = '0;
    #1;
    check("t1 rsp_valid",   vec_t'(bus.rsp_valid), vec_t'(4'b0001));
    check("t1 rsp_q",       bus.rsp_q, ramp(2, 2));
    check("t1 pe idle",     vec_t'(bus.pe_d1_valid), '0);
    check("t1 outstanding0", vec_t'(bus.outstanding), '0);
    @(negedge clk);
    #1;
    check("t1 rsp_valid off", vec_t'(bus.rsp_valid), '0);

    // Backpressure holds req2 for 5 cycles, then it is granted at once
    do_reset();
    @(negedge clk);
    bus.req_valid = 4'b0100;
    bus.pe_d1_bp  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      check($sformatf("t3 bp ack c%0d", c), vec_t'(bus.req_ack), '0);
      check($sformatf("t3 bp pe c%0d", c), vec_t'(bus.pe_d1_valid), '0);
      @(negedge clk);
    end
    bus.pe_d1_bp = 1'b0;
    #1;
    check("t3 ack after bp", vec_t'(bus.req_ack), vec_t'(4'b0100));
    @(negedge clk);
    bus.req_valid = '0;
    #1;
    check("t3 issue", vec_t'(bus.pe_d1_valid), vec_t'(1'b1));

    // Stalled pe_add: rotation fills the FIFO, then a pop allows a same-cycle grant
    do_reset();
    @(negedge clk);
    bus.req_valid = 4'b1111;
    acks = 0;
    for (int c = 0; c < MAX_OUT; c++) begin
      #1;
      exp_ack = '0;
      exp_ack[c % NREQ] = 1'b1;
      check($sformatf("t4 ack c%0d", c), vec_t'(bus.req_ack), vec_t'(exp_ack));
      if (bus.req_ack != '0) acks++;
      @(negedge clk);
    end
    #1;
    check("t4 ack count",   vec_t'(acks), vec_t'(MAX_OUT));
    check("t4 outstanding", vec_t'(bus.outstanding), vec_t'(MAX_OUT));
    check("t4 full no ack", vec_t'(bus.req_ack), '0);
    @(negedge clk);
    bus.pe_q_valid = 1'b1;
    #1;
    check("t4 pop ack", vec_t'(bus.req_ack), vec_t'(4'b0001));
    @(negedge clk);
    bus.pe_q_valid = 1'b0;
    bus.req_valid  = '0;
    #1;
    check("t4 occ after swap", vec_t'(bus.outstanding), vec_t'(MAX_OUT));
    check("t4 rsp routed", vec_t'(bus.rsp_valid), vec_t'(4'b0001));

    // Orphan result sets sticky ERR and produces no response
    do_reset();
    @(negedge clk);
    bus.pe_q_valid = 1'b1;
    bus.pe_q       = ramp(5, 1);
    @(negedge clk);
    bus.pe_q_valid = 1'b0;
    #1;
    check("t5 err",         vec_t'(bus.err), vec_t'(1'b1));
    check("t5 rsp_valid",   vec_t'(bus.rsp_valid), '0);
    check("t5 outstanding", vec_t'(bus.outstanding), '0);
    @(negedge clk);
    #1;
    check("t5 err sticky",   vec_t'(bus.err), vec_t'(1'b1));
    check("t5 rsp_valid2",   vec_t'(bus.rsp_valid), '0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("t5 err cleared", vec_t'(bus.err), '0);

    // Reset with 3 outstanding discards everything and restarts at req0
    do_reset();
    @(negedge clk);
    bus.req_valid = 4'b1111;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("t6 outstanding3", vec_t'(bus.outstanding), vec_t'(3));
    check("t6 no ack in rst", vec_t'(bus.req_ack), '0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("t6 outstanding0", vec_t'(bus.outstanding), '0);
    check("t6 pe_d1_valid",  vec_t'(bus.pe_d1_valid), '0);
    check("t6 pe_d1",        bus.pe_d1, '0);
    check("t6 rsp_valid",    vec_t'(bus.rsp_valid), '0);
    check("t6 err",          vec_t'(bus.err), '0);
    check("t6 ptr restart",  vec_t'(bus.req_ack), vec_t'(4'b0001));

    // Randomized traffic against a queue-based reference
    do_reset();
    rv         = '0;
    mptr       = 0;
    exp_pe_vld = 1'b0;
    exp_d1     = '0;
    exp_d2     = '0;
    exp_rsp    = '0;
    exp_rsp_q  = '0;
    mtags.delete();
    pe_pipe.delete();
    for (int cyc = 0; cyc < 800; cyc++) begin
      @(negedge clk);
      #1;
      check("rnd pe_d1_valid", vec_t'(bus.pe_d1_valid), vec_t'(exp_pe_vld));
      check("rnd pe_d2_valid", vec_t'(bus.pe_d2_valid), vec_t'(exp_pe_vld));
      check("rnd pe_d1", bus.pe_d1, exp_d1);
      check("rnd pe_d2", bus.pe_d2, exp_d2);
      check("rnd rsp_valid", vec_t'(bus.rsp_valid), vec_t'(exp_rsp));
      if (exp_rsp != '0) check("rnd rsp_q", bus.rsp_q, exp_rsp_q);
      check("rnd outstanding", vec_t'(bus.outstanding), vec_t'(mtags.size()));
      if (bus.pe_d1_valid) pe_pipe.push_back(lsum(bus.pe_d1, bus.pe_d2));

      for (int i = 0; i < NREQ; i++) begin
        if (!rv[i] && $urandom_range(0, 2) == 0) begin
          rv[i]  = 1'b1;
          rd1[i] = rand_vec();
          rd2[i] = rand_vec();
        end
        bus.req_d1[i*DW +: DW] = rd1[i];
        bus.req_d2[i*DW +: DW] = rd2[i];
      end
      bus.req_valid = rv;
      bp1 = ($urandom_range(0, 5) == 0);
      bp2 = ($urandom_range(0, 5) == 0);
      bus.pe_d1_bp = bp1;
      bus.pe_d2_bp = bp2;
      qv = (pe_pipe.size() != 0) &&
           ($urandom_range(0, 9) < (((cyc / 150) % 2) != 0 ? 2 : 7));
      bus.pe_q_valid = qv;
      bus.pe_q       = qv ? pe_pipe.pop_front() : '0;
      #1;

      g = -1;
      if (!bp1 && !bp2 && (mtags.size() < MAX_OUT || qv)) begin
        for (int k = 0; k < NREQ; k++) begin
          if (g < 0 && rv[(mptr + k) % NREQ]) g = (mptr + k) % NREQ;
        end
      end
      exp_ack = '0;
      if (g >= 0) exp_ack[g] = 1'b1;
      check("rnd ack", vec_t'(bus.req_ack), vec_t'(exp_ack));

      exp_rsp = '0;
      if (qv && mtags.size() != 0) begin
        t = mtags.pop_front();
        exp_rsp[t.id] = 1'b1;
        exp_rsp_q     = t.sum;
      end
      exp_pe_vld = (g >= 0);
      exp_d1     = '0;
      exp_d2     = '0;
      if (g >= 0) begin
        exp_d1 = rd1[g];
        exp_d2 = rd2[g];
        mtags.push_back('{g, lsum(rd1[g], rd2[g])});
        rv[g] = 1'b0;
        mptr  = (g + 1) % NREQ;
      end
    end
    @(negedge clk);
    #1;
    check("rnd err clear", vec_t'(bus.err), '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
